// File: rtl/multi_edge_detect_if.sv
// Channel-side signal bundle for multi_edge_detect: raw inputs and run-time
// controls in, filtered levels, event pulses, pending flags and interrupt out.
interface multi_edge_detect_if #(
    parameter int NUM_CH = 8
);
    logic [NUM_CH-1:0]   d_i;
    logic [2*NUM_CH-1:0] mode_i;
    logic [NUM_CH-1:0]   clr_i;
    logic [NUM_CH-1:0]   ien_i;
    logic [NUM_CH-1:0]   level_o;
    logic [NUM_CH-1:0]   pulse_o;
    logic [NUM_CH-1:0]   pend_o;
    logic                irq_o;

    modport master (
        output d_i, mode_i, clr_i, ien_i,
        input  level_o, pulse_o, pend_o, irq_o
    );

    modport slave (
        input  d_i, mode_i, clr_i, ien_i,
        output level_o, pulse_o, pend_o, irq_o
    );
endinterface

// File: rtl/multi_edge_detect.sv
// Multi-channel synchronising, debouncing edge detector with per-channel mode,
// sticky write-1-to-clear pending flags and a masked interrupt OR.
module med_chan #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 0,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pulse,
    output logic       pend
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   flt;
    logic                   change;
    logic                   qual;
    logic                   pulse_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= {SYNC_STAGES{RST_LEVEL}};
        else     sync <= {sync[SYNC_STAGES-2:0], d};
    end
    assign s = sync[SYNC_STAGES-1];

    if (DEB_CYCLES == 0) begin : g_nodeb
        assign change = (s != flt);
    end else begin : g_deb
        localparam int             CW      = $clog2(DEB_CYCLES + 1);
        localparam logic [CW-1:0]  DEB_MAX = CW'(DEB_CYCLES);
        logic [CW-1:0] cnt;

        // A new level must be seen on DEB_CYCLES+1 consecutive edges; any
        // sample equal to flt restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                             cnt <= '0;
            else if (s == flt || cnt >= DEB_MAX) cnt <= '0;
            else                                 cnt <= cnt + 1'b1;
        end
        assign change = (s != flt) && (cnt >= DEB_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         flt <= RST_LEVEL;
        else if (change) flt <= s;
    end
    assign level = flt;

    // mode[0] enables rises, mode[1] falls; the ~pulse term keeps the pulse
    // one cycle wide even when an undebounced input toggles every cycle.
    assign qual       = s ? mode[0] : mode[1];
    assign pulse_next = change & qual & ~pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse <= 1'b0;
            pend  <= 1'b0;
        end else begin
            pulse <= pulse_next;
            pend  <= (pend & ~clr) | pulse_next;
        end
    end
endmodule

module multi_edge_detect #(
    parameter int   NUM_CH      = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 0,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    multi_edge_detect_if.slave   bus
);
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] pend;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        med_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .RST_LEVEL   (RST_LEVEL)
        ) u_ch (
            .clk   (sys_clk),
            .rst   (sys_rst),
            .d     (bus.d_i[g]),
            .mode  (bus.mode_i[2*g+1 -: 2]),
            .clr   (bus.clr_i[g]),
            .level (level[g]),
            .pulse (pulse[g]),
            .pend  (pend[g])
        );
    end

    assign bus.level_o = level;
    assign bus.pulse_o = pulse;
    assign bus.pend_o  = pend;
    assign bus.irq_o   = |(pend & bus.ien_i);
endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench: default-parameter instance (SYNC 2, no debounce) and a
// SYNC 3 / DEB 4 instance, with hand-computed pulse timing per scenario.
module tb_multi_edge_detect;
    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multi_edge_detect_if #(.NUM_CH(8)) b0 ();
    multi_edge_detect_if #(.NUM_CH(8)) b1 ();

    multi_edge_detect #(.NUM_CH(8)) dut0 (
        .sys_clk (clk),
        .sys_rst (rst0),
        .bus     (b0)
    );

    multi_edge_detect #(.NUM_CH(8), .SYNC_STAGES(3), .DEB_CYCLES(4)) dut1 (
        .sys_clk (clk),
        .sys_rst (rst1),
        .bus     (b1)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        b0.d_i = '0; b0.mode_i = '0; b0.clr_i = '0; b0.ien_i = '0;
        b1.d_i = '0; b1.mode_i = '0; b1.clr_i = '0; b1.ien_i = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        tick(2);
        tests++; if (b0.level_o !== 8'h00) begin fails++; $display("FAIL reset_level0: got %h exp 00", b0.level_o); end
        tests++; if (b0.pulse_o !== 8'h00) begin fails++; $display("FAIL reset_pulse0: got %h exp 00", b0.pulse_o); end
        tests++; if (b0.pend_o  !== 8'h00) begin fails++; $display("FAIL reset_pend0: got %h exp 00", b0.pend_o); end
        tests++; if (b0.irq_o   !== 1'b0)  begin fails++; $display("FAIL reset_irq0: got %b exp 0", b0.irq_o); end
        tests++; if (b1.level_o !== 8'h00) begin fails++; $display("FAIL reset_level1: got %h exp 00", b1.level_o); end
        rst0 = 1'b0; rst1 = 1'b0;
        tick(4);
        tests++; if (b0.pulse_o !== 8'h00) begin fails++; $display("FAIL idle_pulse0: got %h exp 00", b0.pulse_o); end
    endtask

    task automatic test_rise_fall();
        logic exp;
        b0.mode_i[1:0] = 2'b01;
        b0.d_i[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp = (e == 3);
            tests++; if (b0.pulse_o[0] !== exp) begin fails++; $display("FAIL rise_pulse e=%0d: got %b exp %b", e, b0.pulse_o[0], exp); end
            exp = (e >= 3);
            tests++; if (b0.pend_o[0] !== exp) begin fails++; $display("FAIL rise_pend e=%0d: got %b exp %b", e, b0.pend_o[0], exp); end
        end
        b0.d_i[0] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            tests++; if (b0.pulse_o[0] !== 1'b0) begin fails++; $display("FAIL fall_nopulse e=%0d: got %b exp 0", e, b0.pulse_o[0]); end
            exp = (e < 3);
            tests++; if (b0.level_o[0] !== exp) begin fails++; $display("FAIL fall_level e=%0d: got %b exp %b", e, b0.level_o[0], exp); end
        end
        b0.clr_i[0] = 1'b1; tick(); b0.clr_i[0] = 1'b0;
        tests++; if (b0.pend_o[0] !== 1'b0) begin fails++; $display("FAIL rise_clr: got %b exp 0", b0.pend_o[0]); end
    endtask

    task automatic test_modes();
        logic w, e1, e2;
        b0.mode_i[3:2] = 2'b11;
        b0.mode_i[5:4] = 2'b10;
        for (int i = 0; i < 20; i++) begin
            w = (i < 16) && ((i % 8) < 4);
            b0.d_i[1] = w; b0.d_i[2] = w;
            tick();
            e1 = (i == 2) || (i == 6) || (i == 10) || (i == 14);
            e2 = (i == 6) || (i == 14);
            tests++; if (b0.pulse_o[1] !== e1) begin fails++; $display("FAIL both_ch1 i=%0d: got %b exp %b", i, b0.pulse_o[1], e1); end
            tests++; if (b0.pulse_o[2] !== e2) begin fails++; $display("FAIL fall_ch2 i=%0d: got %b exp %b", i, b0.pulse_o[2], e2); end
            tests++; if (b0.pulse_o[0] !== 1'b0) begin fails++; $display("FAIL quiet_ch0 i=%0d: got %b exp 0", i, b0.pulse_o[0]); end
        end
        tests++; if (b0.pend_o[2:1] !== 2'b11) begin fails++; $display("FAIL modes_pend: got %b exp 11", b0.pend_o[2:1]); end
        b0.clr_i = 8'h06; tick(); b0.clr_i = '0;
    endtask

    task automatic test_clear();
        b0.mode_i[7:6] = 2'b01;
        b0.ien_i[3] = 1'b1;
        b0.d_i[3] = 1'b1; tick(3);
        tests++; if (b0.pend_o[3] !== 1'b1) begin fails++; $display("FAIL clr_set: got %b exp 1", b0.pend_o[3]); end
        tests++; if (b0.irq_o !== 1'b1) begin fails++; $display("FAIL clr_irq_set: got %b exp 1", b0.irq_o); end
        b0.clr_i[3] = 1'b1; tick(); b0.clr_i[3] = 1'b0;
        tests++; if (b0.pend_o[3] !== 1'b0) begin fails++; $display("FAIL clr_drop: got %b exp 0", b0.pend_o[3]); end
        tests++; if (b0.irq_o !== 1'b0) begin fails++; $display("FAIL clr_irq_drop: got %b exp 0", b0.irq_o); end
        b0.d_i[3] = 1'b0; tick(4);
        b0.d_i[3] = 1'b1; tick(3);
        b0.d_i[3] = 1'b0; tick(4);
        tests++; if (b0.pend_o[3] !== 1'b1) begin fails++; $display("FAIL clr_resticky: got %b exp 1", b0.pend_o[3]); end
        b0.d_i[3] = 1'b1; tick(2);
        b0.clr_i[3] = 1'b1; tick(); b0.clr_i[3] = 1'b0;
        tests++; if (b0.pulse_o[3] !== 1'b1) begin fails++; $display("FAIL clr_race_pulse: got %b exp 1", b0.pulse_o[3]); end
        tests++; if (b0.pend_o[3] !== 1'b1) begin fails++; $display("FAIL clr_race_pend: got %b exp 1", b0.pend_o[3]); end
        tick();
        tests++; if (b0.pend_o[3] !== 1'b1) begin fails++; $display("FAIL clr_race_hold: got %b exp 1", b0.pend_o[3]); end
        b0.ien_i[3] = 1'b0; #1;
        tests++; if (b0.irq_o !== 1'b0) begin fails++; $display("FAIL mask_irq: got %b exp 0", b0.irq_o); end
        tests++; if (b0.pend_o[3] !== 1'b1) begin fails++; $display("FAIL mask_pend: got %b exp 1", b0.pend_o[3]); end
        b0.clr_i[3] = 1'b1; tick(); b0.clr_i[3] = 1'b0;
    endtask

    task automatic test_all_reset_release();
        logic [7:0] exp;
        rst0 = 1'b1;
        b0.d_i = 8'hFF;
        b0.mode_i = 16'h5555;
        tick();
        tests++; if (b0.pulse_o !== 8'h00) begin fails++; $display("FAIL rel_inreset: got %h exp 00", b0.pulse_o); end
        rst0 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp = (e == 3) ? 8'hFF : 8'h00;
            tests++; if (b0.pulse_o !== exp) begin fails++; $display("FAIL rel_pulse e=%0d: got %h exp %h", e, b0.pulse_o, exp); end
        end
        tests++; if (b0.level_o !== 8'hFF) begin fails++; $display("FAIL rel_level: got %h exp ff", b0.level_o); end
    endtask

    task automatic test_debounce();
        logic exp;
        b1.mode_i[1:0] = 2'b01;
        b1.d_i[0] = 1'b1; tick(3);
        b1.d_i[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++; if (b1.pulse_o[0] !== 1'b0) begin fails++; $display("FAIL glitch_pulse i=%0d: got %b exp 0", i, b1.pulse_o[0]); end
            tests++; if (b1.level_o[0] !== 1'b0) begin fails++; $display("FAIL glitch_level i=%0d: got %b exp 0", i, b1.level_o[0]); end
        end
        b1.d_i[0] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp = (e == 8);
            tests++; if (b1.pulse_o[0] !== exp) begin fails++; $display("FAIL deb_pulse e=%0d: got %b exp %b", e, b1.pulse_o[0], exp); end
            exp = (e >= 8);
            tests++; if (b1.level_o[0] !== exp) begin fails++; $display("FAIL deb_level e=%0d: got %b exp %b", e, b1.level_o[0], exp); end
        end
    endtask

    task automatic test_reset_mid_debounce();
        b1.ien_i = 8'hFF;
        #1;
        tests++; if (b1.irq_o !== 1'b1) begin fails++; $display("FAIL mid_irq_pre: got %b exp 1", b1.irq_o); end
        rst1 = 1'b1;
        b1.d_i = 8'hFF;
        b1.mode_i = 16'h5555;
        tick();
        rst1 = 1'b0;
        tick(6);
        tests++; if (b1.pulse_o !== 8'h00) begin fails++; $display("FAIL mid_early: got %h exp 00", b1.pulse_o); end
        rst1 = 1'b1; #1;
        tests++; if (b1.level_o !== 8'h00) begin fails++; $display("FAIL mid_level: got %h exp 00", b1.level_o); end
        tests++; if (b1.pend_o !== 8'h00) begin fails++; $display("FAIL mid_pend: got %h exp 00", b1.pend_o); end
        tests++; if (b1.irq_o !== 1'b0) begin fails++; $display("FAIL mid_irq: got %b exp 0", b1.irq_o); end
        b1.d_i = 8'h00;
        tick();
        rst1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++; if (b1.pulse_o !== 8'h00) begin fails++; $display("FAIL mid_nopulse i=%0d: got %h exp 00", i, b1.pulse_o); end
        end
        tests++; if (b1.level_o !== 8'h00) begin fails++; $display("FAIL mid_level_after: got %h exp 00", b1.level_o); end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_modes();
        test_clear();
        test_all_reset_release();
        test_debounce();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Multi-channel, parametrised edge detector for asynchronous or bouncy inputs (buttons, external strobes, sensor lines). Each channel is synchronised into `sys_clk`, optionally debounced, and produces a one-cycle event pulse on rising, falling or both edges, selected per channel at run time. Events also set sticky pending flags with write-1-to-clear and a combined interrupt output, so slower control logic or a CPU register bank can service them without missing short pulses.

## Interface
- `NUM_CH`, 8: number of independent channels, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per channel, at least 2.
- `DEB_CYCLES`, 0: debounce length, 0..65535. 0 means no debounce. Counter width is clog2(DEB_CYCLES+1), minimum 1.
- `RST_LEVEL`, 1'b0: reset value of every synchroniser stage and filtered level, for all channels.
- `sys_clk` in 1: the single clock; all state is on its rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `d_i` in NUM_CH: raw, asynchronous channel inputs.
- `mode_i` in 2*NUM_CH: channel n uses bits [2n+1:2n]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- `clr_i` in NUM_CH: write-1-to-clear strobe for `pend_o`.
- `ien_i` in NUM_CH: per-channel interrupt enable.
- `level_o` out NUM_CH: filtered (synchronised, debounced) level.
- `pulse_o` out NUM_CH: one-cycle event pulse, registered.
- `pend_o` out NUM_CH: sticky pending flags, registered.
- `irq_o` out 1: OR-reduce of `pend_o & ien_i`, combinational from registers.

## Operation
- **Reset values** (while `sys_rst` is high, asynchronously):
  - sync stages and `level_o` = RST_LEVEL
  - debounce counters = 0
  - `pulse_o` = 0, `pend_o` = 0, so `irq_o` = 0
- **Synchroniser:** a shift chain of SYNC_STAGES flops per channel. `s` is the last stage.
- **Debounce:** per channel, one counter `cnt` and the filtered level `flt` (= `level_o`). On each edge:
  - if `s == flt`: `cnt <= 0`
  - else if `cnt >= DEB_CYCLES`: `flt <= s`, `cnt <= 0`, and a change is flagged
  - else: `cnt <= cnt + 1`
  - Net effect: a new level must be sampled on DEB_CYCLES+1 consecutive edges before `flt` follows it. Any glitch back to `flt` restarts the count.
- **Edge qualify:** on the edge where `flt` changes, `pulse_o[n] <= 1` only if the mode allows it:
  - rise (new level 1) needs mode 01 or 11
  - fall (new level 0) needs mode 10 or 11
  - otherwise `pulse_o[n] <= 0`
- **Pulse width:** `pulse_o` is high for exactly one cycle per qualified change. It is never high on consecutive cycles for the same channel.
- **Mode independence:** `flt` tracks the input regardless of mode. Changing `mode_i` never creates a pulse by itself; a new mode applies to changes on the next edge onward.
- **Pending flags:** `pend_o[n] <= (pend_o[n] & ~clr_i[n]) | pulse_next[n]`. When set and clear hit the same edge, set wins and the flag stays 1.
- **Interrupt:** `irq_o` updates whenever `pend_o` or `ien_i` change. Masking a channel does not clear its pending flag.
- **Input already away from RST_LEVEL at reset release:** treated as a real edge. The channel fires a pulse after normal latency if its mode allows.
- **Reset mid-debounce:** the partial count is discarded and no pulse is produced from the interrupted change.

## Timing
- **Latency** from a `d_i` change, meeting setup before edge 1, to `level_o`/`pulse_o` (and `pend_o`) changing: edge SYNC_STAGES+DEB_CYCLES+1.
  - Defaults: edge 3.
  - SYNC_STAGES=3, DEB_CYCLES=4: edge 8.
- **Minimum input hold** for detection: DEB_CYCLES+1 cycles. With DEB_CYCLES=0, one sampled cycle suffices.
- **Clear:** `pend_o` drops on the edge after `clr_i` is sampled high; `irq_o` drops in the same cycle.
- **Channel independence:** channels are fully independent. Simultaneous events on different channels each pulse in the same cycle.

## Test plan
- **Default parameters, ch0 mode 01:**
  - `d_i[0]` goes 0->1 before edge 1 -> `pulse_o[0]` high during cycle after edge 3 only, and `pend_o[0]=1`.
  - `d_i[0]` then goes 1->0 -> no pulse, but `level_o[0]` falls at edge 3 after the change.
- **Mode 11 on ch1, mode 10 on ch2, same square wave (period 8) on both** -> ch1 pulses on every transition; ch2 pulses only on falls, 8 cycles apart.
- **DEB_CYCLES=4, 3-cycle glitch, then 5-cycle high on ch0 (mode 01):**
  - glitch -> no `level_o` change and no pulse
  - 5-cycle high -> pulse at edge SYNC_STAGES+5 after its start
- **`pend_o[3]=1` with `ien_i[3]=1`:**
  - `clr_i[3]` pulsed -> `pend_o[3]` and `irq_o` drop next edge
  - repeat with `clr_i[3]` coinciding with a new pulse -> `pend_o[3]` stays 1
- **Hold `d_i=all 1`, RST_LEVEL=0, all modes 01, release `sys_rst`** -> all channels pulse together at edge 3.
  - Assert `sys_rst` mid-debounce -> all outputs 0 immediately, no later pulse.
